// File: rtl/my_mem_pkg.sv
// Shared types and helpers for the parity-protected memory controller.
// Supplies lane-count derivation, the default stored-word layout and the per-lane parity function.
package my_mem_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int MAX_DATA_W = 256;
  localparam int MAX_NL     = MAX_DATA_W / 8;

  function automatic int num_lanes(input int data_w);
    return data_w / 8;
  endfunction

  localparam int DEF_NL = num_lanes(DEF_DATA_W);

  typedef struct packed {
    logic [DEF_NL-1:0]     par;
    logic [DEF_DATA_W-1:0] data;
  } mem_word_t;

  // Callers zero-extend narrower data; the unused upper lanes then come out as 0.
  function automatic logic [MAX_NL-1:0] lane_parity(input logic [MAX_DATA_W-1:0] data);
    logic [MAX_NL-1:0] p;
    p = '0;
    for (int i = 0; i < MAX_NL; i++) begin
      p[i] = ^data[8*i +: 8];
    end
    return p;
  endfunction

endpackage

// File: rtl/my_mem_parity.sv
// Combinational even-parity generator, one bit per byte lane.
// DATA_W must be a multiple of 8 and no wider than MAX_DATA_W.
module my_mem_parity
  import my_mem_pkg::*;
#(
  parameter  int DATA_W = 8,
  localparam int NL     = DATA_W / 8
) (
  input  logic [DATA_W-1:0] i_data,
  output logic [NL-1:0]     o_par
);

  assign o_par = NL'(lane_parity(MAX_DATA_W'(i_data)));

endmodule

// File: rtl/my_mem_par_ctrl.sv
// Single-port memory with per-lane parity, read checking, saturating error counter,
// written-location tracking and read/write collision flagging.
module my_mem_par_ctrl
  import my_mem_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int ADDR_W = 8,
  parameter  int CNT_W  = 8,
  localparam int NL     = DATA_W / 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 write,
  input  logic                 read,
  input  logic [ADDR_W-1:0]    address,
  input  logic [DATA_W-1:0]    data_in,
  input  logic                 inject_err,
  input  logic                 clr_err,
  output logic [NL+DATA_W-1:0] data_out,
  output logic                 rd_valid,
  output logic                 par_err,
  output logic                 uninit,
  output logic                 collision,
  output logic [CNT_W-1:0]     error_count
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef struct packed {
    logic [NL-1:0]     par;
    logic [DATA_W-1:0] data;
  } word_t;

  word_t             r_mem [DEPTH];
  logic [DEPTH-1:0]  r_wr_seen;
  word_t             r_data_out;
  logic              r_rd_valid;
  logic              r_par_err;
  logic              r_uninit;
  logic              r_collision;
  logic [CNT_W-1:0]  r_err_cnt;

  logic              w_do_write;
  logic              w_do_read;
  logic              w_both;
  logic [NL-1:0]     w_wr_par;
  word_t             w_wr_word;
  word_t             w_rd_word;
  logic [NL-1:0]     w_rd_par;
  logic              w_mismatch;
  logic              w_seen;
  logic              w_cnt_inc;

  assign w_do_write = write & ~read;
  assign w_do_read  = read & ~write;
  assign w_both     = read & write;

  my_mem_parity #(.DATA_W(DATA_W)) u_wr_parity (
    .i_data (data_in),
    .o_par  (w_wr_par)
  );

  // The test hook flips only lane 0 so a single, predictable lane reports the error.
  assign w_wr_word.par  = w_wr_par ^ NL'(inject_err);
  assign w_wr_word.data = data_in;

  assign w_rd_word = r_mem[address];
  assign w_seen    = r_wr_seen[address];

  my_mem_parity #(.DATA_W(DATA_W)) u_rd_parity (
    .i_data (w_rd_word.data),
    .o_par  (w_rd_par)
  );

  assign w_mismatch = |(w_rd_par ^ w_rd_word.par);
  assign w_cnt_inc  = w_do_read & w_seen & w_mismatch & ~(&r_err_cnt);

  // Storage is deliberately not reset; validity comes from r_wr_seen instead.
  always_ff @(posedge clk) begin
    if (w_do_write) begin
      r_mem[address] <= w_wr_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_seen <= '0;
    end else if (w_do_write) begin
      r_wr_seen[address] <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_out <= '0;
      r_rd_valid <= 1'b0;
      r_par_err  <= 1'b0;
      r_uninit   <= 1'b0;
    end else if (w_do_read) begin
      r_rd_valid <= 1'b1;
      if (w_seen) begin
        r_data_out <= w_rd_word;
        r_par_err  <= w_mismatch;
        r_uninit   <= 1'b0;
      end else begin
        r_data_out <= '0;
        r_par_err  <= 1'b0;
        r_uninit   <= 1'b1;
      end
    end else begin
      r_rd_valid <= 1'b0;
      r_par_err  <= 1'b0;
      r_uninit   <= 1'b0;
    end
  end

  // A clear request takes priority over an increment arriving on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt   <= '0;
      r_collision <= 1'b0;
    end else begin
      r_collision <= w_both;
      if (clr_err) begin
        r_err_cnt <= '0;
      end else if (w_cnt_inc) begin
        r_err_cnt <= r_err_cnt + 1'b1;
      end
    end
  end

  assign data_out    = r_data_out;
  assign rd_valid    = r_rd_valid;
  assign par_err     = r_par_err;
  assign uninit      = r_uninit;
  assign collision   = r_collision;
  assign error_count = r_err_cnt;

endmodule
